// File: rtl/seq_alu.sv
// Clocked ALU with a start/done handshake. Add/sub/logic/shift ops finish one cycle
// after acceptance; signed multiply (Booth radix-2) and divide (restoring) iterate WIDTH times.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [3:0]       opCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] zOutLow,
  output logic [WIDTH-1:0] zOutHigh,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             zero,
  output logic             dbz,
  output logic             illegal
);
  localparam logic [3:0] OP_SUB = 4'b0001, OP_MUL = 4'b0010, OP_DIV = 4'b0011,
                         OP_SHL = 4'b0100, OP_SHR = 4'b0101, OP_ROL = 4'b0110,
                         OP_ROR = 4'b0111, OP_AND = 4'b1000, OP_OR  = 4'b1001,
                         OP_NEG = 4'b1010, OP_NOT = 4'b1011, OP_SRA = 4'b1100,
                         OP_ADD = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_q;
  logic [WIDTH:0]   r_acc;
  logic             r_q1;
  logic [SHW-1:0]   r_cnt;

  logic [SHW-1:0]   w_amt;
  logic [WIDTH:0]   w_sum, w_addend, w_booth, w_rshift, w_rdiff;
  logic [WIDTH-1:0] w_dmag, w_lo, w_hi;
  logic             w_rfit, w_carry, w_dbz, w_ill;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input logic [SHW-1:0] n);
    logic [2*WIDTH-1:0] t;
    t = {v, v} << n;
    return t[2*WIDTH-1:WIDTH];
  endfunction

  assign w_amt    = r_b[SHW-1:0];
  assign w_addend = {r_a[WIDTH-1], r_a};
  assign w_dmag   = mag(r_b);
  assign w_rshift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_rdiff  = w_rshift - {1'b0, w_dmag};
  assign w_rfit   = (w_rshift >= {1'b0, w_dmag});

  // Booth step: the multiplier bit pair selects +A, -A or nothing before the shift
  always_comb begin
    case ({r_q[0], r_q1})
      2'b01:   w_booth = r_acc + w_addend;
      2'b10:   w_booth = r_acc - w_addend;
      default: w_booth = r_acc;
    endcase
  end

  always_comb begin
    w_lo    = '0;
    w_hi    = '0;
    w_carry = 1'b0;
    w_dbz   = 1'b0;
    w_ill   = 1'b0;
    w_sum   = {1'b0, r_a} + {1'b0, r_b};
    case (r_op)
      OP_ADD: begin w_lo = w_sum[WIDTH-1:0]; w_carry = w_sum[WIDTH]; end
      OP_SUB: begin w_lo = r_a - r_b; w_carry = (r_a < r_b); end
      OP_MUL: begin w_lo = r_q; w_hi = r_acc[WIDTH-1:0]; end
      OP_DIV: begin
        if (r_b == '0) begin
          w_lo  = '1;
          w_hi  = r_a;
          w_dbz = 1'b1;
        end else begin
          // Magnitude result corrected: quotient by sign xor, remainder follows dividend
          w_lo = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -r_q : r_q;
          w_hi = r_a[WIDTH-1] ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        end
      end
      OP_SHL: w_lo = r_a << w_amt;
      OP_SHR: w_lo = r_a >> w_amt;
      OP_SRA: w_lo = $signed(r_a) >>> w_amt;
      OP_ROL: w_lo = rotl(r_a, w_amt);
      OP_ROR: w_lo = rotl(r_a, SHW'(WIDTH - int'(w_amt)));
      OP_AND: w_lo = r_a & r_b;
      OP_OR:  w_lo = r_a | r_b;
      OP_NEG: w_lo = -r_b;
      OP_NOT: w_lo = ~r_b;
      default: w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_q      <= '0;
      r_acc    <= '0;
      r_q1     <= 1'b0;
      r_cnt    <= '0;
      zOutLow  <= '0;
      zOutHigh <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      dbz      <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= opCode;
            r_a   <= A;
            r_b   <= B;
            busy  <= 1'b1;
            r_acc <= '0;
            r_q1  <= 1'b0;
            r_cnt <= SHW'(WIDTH - 1);
            if (opCode == OP_MUL) begin
              r_q     <= B;
              r_state <= S_CALC;
            end else if (opCode == OP_DIV && B != '0) begin
              r_q     <= mag(A);
              r_state <= S_CALC;
            end else begin
              r_q     <= '0;
              r_state <= S_DONE;
            end
          end
        end
        S_CALC: begin
          if (r_op == OP_MUL) begin
            r_acc <= {w_booth[WIDTH], w_booth[WIDTH:1]};
            r_q   <= {w_booth[0], r_q[WIDTH-1:1]};
            r_q1  <= r_q[0];
          end else begin
            r_acc <= w_rfit ? w_rdiff : w_rshift;
            r_q   <= {r_q[WIDTH-2:0], w_rfit};
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_DONE;
        end
        // Commit edge: results and flags of the finished op become visible with done
        S_DONE: begin
          zOutLow  <= w_lo;
          zOutHigh <= w_hi;
          carry    <= w_carry;
          zero     <= (w_lo == '0);
          dbz      <= w_dbz;
          illegal  <= w_ill;
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, clocked successor to the datapath's combinational ALU. It keeps the same 4-bit opcode map and the low/high result pair. It adds a start/done handshake, registered results, multi-bit shift amounts, status flags, and iterative signed multiply/divide that take WIDTH iterations instead of a single-cycle array. It sits between the A/B operand registers and the Z register pair (ZLow/ZHigh) in the CPU datapath; the control unit issues start and waits for done.

Parameters:
WIDTH, 32, operand and result width; must be a power of two, 8 to 64
SHW, $clog2(WIDTH), derived; number of low bits of B used as the shift/rotate amount

Ports:
clock  in  1  system clock; all state updates on rising edge
clear_n  in  1  asynchronous, active-low reset
start  in  1  request; sampled on a rising edge only while busy=0
opCode  in  4  operation select, sampled with start
A  in  WIDTH  operand A, sampled with start
B  in  WIDTH  operand B / shift amount, sampled with start
zOutLow  out  WIDTH  low result / quotient
zOutHigh  out  WIDTH  high product / remainder / carry word
busy  out  1  high while an accepted operation is in progress
done  out  1  one-cycle pulse marking a valid, updated result
carry  out  1  Add carry-out, Sub borrow-out; 0 for other ops
zero  out  1  zOutLow == 0, updated together with done
dbz  out  1  divide by zero on the last Div
illegal  out  1  unrecognised opcode on the last operation

Behaviour:
- Reset (clear_n=0, asynchronous): state IDLE; all outputs 0; operand and working registers 0. Deasserting mid-operation aborts it: no done pulse, results stay 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at an edge: latch opCode, A and B. That edge is the accept edge; busy=1 from it.
  - Single-cycle ops go to DONE. Mul and Div with B!=0 go to CALC with the iteration counter at WIDTH-1.
- CALC:
  - One radix-2 step per cycle. Mul: signed shift-add (Booth radix-2). Div: restoring division on magnitudes.
  - After WIDTH steps: apply sign correction, register results, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. done is high at edge 1 after the accept edge for single-cycle ops, and at edge WIDTH+1 for Mul/Div.
- Back-to-back: start may be accepted in the DONE cycle (busy=0). That edge is the new accept edge.
- start while busy=1 is ignored. Operand changes after the accept edge have no effect.
- Outputs update only at the done edge and hold until the next done or reset.
- zero, dbz, illegal and carry update at every done edge, using the op that completed.
- Opcodes (A op B, WIDTH-bit two's complement, zOutHigh=0 unless stated):
  - 1101 Add: zOutLow=A+B; carry = bit WIDTH of the sum.
  - 0001 Sub: zOutLow=A-B; carry=1 when A<B unsigned.
  - 0010 Mul: signed product, 2*WIDTH bits; zOutLow=low half, zOutHigh=high half.
  - 0011 Div: signed, quotient truncated toward zero, remainder takes the dividend's sign. zOutLow=quotient, zOutHigh=remainder. MIN/-1 gives quotient=MIN, remainder=0.
  - 0011 Div, B=0: 1-cycle latency; zOutLow=all ones, zOutHigh=A, dbz=1.
  - 0100 ShL, 0101 ShR (logical), 1100 SHRA (sign fill), 0110 RoL, 0111 RoR: amount = B[SHW-1:0]. Amount 0 gives zOutLow=A.
  - 1000 And, 1001 Or.
  - 1010 Neg: zOutLow=-B. 1011 Not: zOutLow=~B.
  - 0000, 1110, 1111: illegal=1, zOutLow=0, zOutHigh=0, latency 1.

Test Plan:
- Reset then Add A=0xFFFFFFFF, B=1 -> at edge 1: done pulse; zOutLow=0, zero=1, carry=1, zOutHigh=0, busy low after.
- Mul A=-3, B=7 -> busy 32 cycles, done at edge 33 exactly once; zOutLow=0xFFFFFFEB, zOutHigh=0xFFFFFFFF.
- Div A=-7, B=2 -> done at edge 33: zOutLow=0xFFFFFFFD, zOutHigh=0xFFFFFFFF. Then Div A=5, B=0 -> done at edge 1: dbz=1, zOutLow=0xFFFFFFFF, zOutHigh=5.
- SHRA A=0x80000010, B=4 -> zOutLow=0xF8000001. RoL A=0x80000001, B=33 (amount 1) -> 0x00000003. ShR B=0 -> zOutLow=A.
- Mul accepted, start pulsed with new operands at edge 5 -> ignored, result unchanged. New start in the DONE cycle -> accepted, done one cycle later for a single-cycle op.
- clear_n low at edge 10 of a Div -> busy=0, done never pulses, all outputs 0. opCode 1111 -> illegal=1, outputs 0, latency 1.
